// File: rtl/measure_pkg.sv
// Shared constants for the measurement sequencer: FSM encoding, default sizes
// and the fault fill used for channels whose conversion timed out.
package measure_pkg;

  localparam int CH_NUM_DEF = 20;
  localparam int DW_DEF     = 16;
  localparam int CHW_DEF    = 5;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SEL    = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_CONV   = 3'd3;
  localparam logic [2:0] ST_WAIT   = 3'd4;
  localparam logic [2:0] ST_NEXT   = 3'd5;
  localparam logic [2:0] ST_DONE   = 3'd6;

  // A timed-out slot is filled entirely with this bit (all-ones fault code).
  localparam logic FAULT_FILL = 1'b1;

  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/measure_seq_sync_rise.sv
// Two-flop synchronizer plus single-cycle rising-edge pulse for MCU strobes.
module sync_rise
  import measure_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_last;

  // The chain keeps tracking the pin during reset; r_last is forced high so a
  // line already high when reset releases does not look like a new edge.
  always_ff @(posedge clk) begin
    r_meta <= i_async;
    r_sync <= r_meta;
    if (rst) begin
      r_last <= 1'b1;
    end else begin
      r_last <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_last;

endmodule

// File: rtl/measure_seq.sv
// Measurement sequencer: per start edge, steps all channels through mux select,
// settle, one ADC conversion and result capture, then holds results with done.
module measure_seq
  import measure_pkg::*;
#(
  parameter int CH_NUM      = CH_NUM_DEF,
  parameter int DW          = DW_DEF,
  parameter int CHW         = CHW_DEF,
  parameter int SETTLE_CYC  = 1000,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_sig,
  input  logic [DW-1:0]        adc_data,
  input  logic                 adc_done,
  output logic [CHW-1:0]       ch_sel,
  output logic                 adc_start,
  output logic                 busy,
  output logic                 done_sig,
  output logic [CH_NUM-1:0]    err,
  output logic [CH_NUM*DW-1:0] data
);

  localparam int CNTW = cnt_width(SETTLE_CYC, TIMEOUT_CYC);
  localparam logic [CNTW-1:0] SETTLE_LAST  = CNTW'(SETTLE_CYC - 1);
  localparam logic [CNTW-1:0] TIMEOUT_LAST = CNTW'(TIMEOUT_CYC - 1);
  localparam logic [CHW-1:0]  LAST_CH      = CHW'(CH_NUM - 1);

  logic                         w_start_rise;
  logic [2:0]                   r_state;
  logic [CHW-1:0]               r_idx;
  logic [CNTW-1:0]              r_cnt;
  logic [CHW-1:0]               r_ch_sel;
  logic                         r_adc_start;
  logic                         r_busy;
  logic                         r_done;
  logic [CH_NUM-1:0]            r_err;
  logic [CH_NUM-1:0][DW-1:0]    r_slot;

  sync_rise u_start_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (start_sig),
    .o_rise  (w_start_rise)
  );

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_ch_sel    <= '0;
      r_adc_start <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= '0;
      r_slot      <= '0;
    end else begin
      r_adc_start <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start_rise) begin
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= '0;
            r_slot  <= '0;
            r_idx   <= '0;
            r_state <= ST_SEL;
          end
        end
        ST_SEL: begin
          r_ch_sel <= r_idx;
          r_cnt    <= '0;
          r_state  <= ST_SETTLE;
        end
        ST_SETTLE: begin
          // Request goes out registered so it is high exactly during CONV.
          if (r_cnt == SETTLE_LAST) begin
            r_cnt       <= '0;
            r_adc_start <= 1'b1;
            r_state     <= ST_CONV;
          end else begin
            r_cnt <= r_cnt + CNTW'(1);
          end
        end
        ST_CONV: begin
          r_cnt   <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A result arriving on the timeout cycle still counts as good data.
          if (adc_done) begin
            r_slot[r_idx] <= adc_data;
            r_state       <= ST_NEXT;
          end else if (r_cnt == TIMEOUT_LAST) begin
            r_slot[r_idx] <= {DW{FAULT_FILL}};
            r_err[r_idx]  <= 1'b1;
            r_state       <= ST_NEXT;
          end else begin
            r_cnt <= r_cnt + CNTW'(1);
          end
        end
        ST_NEXT: begin
          if (r_idx == LAST_CH) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_idx   <= r_idx + CHW'(1);
            r_state <= ST_SEL;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ch_sel    = r_ch_sel;
  assign adc_start = r_adc_start;
  assign busy      = r_busy;
  assign done_sig  = r_done;
  assign err       = r_err;
  assign data      = r_slot;

endmodule

// File: tb/tb_measure_seq.sv
// Scoreboard bench for measure_seq: stimulus queues expected conversions and
// run results; a monitor pops and compares on adc_start pulses and done rises.
module tb_measure_seq;

  localparam int CH  = 20;
  localparam int DW  = 16;
  localparam int CHW = 5;

  typedef struct packed {
    logic [CH*DW-1:0] d;
    logic [CH-1:0]    e;
  } res_t;

  logic                clk;
  logic                rst;
  logic                start_sig;
  logic [DW-1:0]       adc_data;
  logic                adc_done;
  logic [CHW-1:0]      ch_sel;
  logic                adc_start;
  logic                busy;
  logic                done_sig;
  logic [CH-1:0]       err;
  logic [CH*DW-1:0]    data;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_cnt = 0;
  logic done_q = 1'b0;
  logic [CHW-1:0] ch_q[$];
  res_t res_q[$];

  logic [15:0] data_base = 16'h0100;
  int          silent_ch = -1;
  int          pend = 0;
  logic [CHW-1:0] pend_ch = '0;

  measure_seq #(
    .CH_NUM(CH), .DW(DW), .CHW(CHW), .SETTLE_CYC(4), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst(rst), .start_sig(start_sig), .adc_data(adc_data),
    .adc_done(adc_done), .ch_sel(ch_sel), .adc_start(adc_start), .busy(busy),
    .done_sig(done_sig), .err(err), .data(data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [CH*DW-1:0] act,
                       input logic [CH*DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  // ADC model: answers 3 cycles after a request unless the channel is silent.
  always @(negedge clk) begin
    adc_done = 1'b0;
    if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0) begin
        adc_done = 1'b1;
        adc_data = data_base + 16'(pend_ch);
      end
    end
    if (adc_start && !(silent_ch >= 0 && int'(ch_sel) == silent_ch)) begin
      pend    = 3;
      pend_ch = ch_sel;
    end
  end

  // Monitor: conversions against channel queue, completed runs against results.
  always @(negedge clk) begin
    res_t r;
    if (!rst && adc_start) begin
      if (ch_q.size() == 0) fail_now("unexpected_conversion");
      else check("conv_ch_sel", (CH*DW)'(ch_sel), (CH*DW)'(ch_q.pop_front()));
    end
    if (done_sig && !done_q) begin
      done_cnt++;
      if (res_q.size() == 0) fail_now("unexpected_done");
      else begin
        r = res_q.pop_front();
        check("run_data", data, r.d);
        check("run_err", (CH*DW)'(err), (CH*DW)'(r.e));
        check("busy_at_done", (CH*DW)'(busy), '0);
      end
    end
    done_q = done_sig;
  end

  task automatic expect_run(input logic [15:0] base, input int silent);
    res_t r;
    r.d = '0;
    r.e = '0;
    for (int k = 0; k < CH; k++) begin
      ch_q.push_back(CHW'(k));
      if (k == silent) begin
        r.d[k*DW +: DW] = 16'hFFFF;
        r.e[k] = 1'b1;
      end else begin
        r.d[k*DW +: DW] = base + 16'(k);
      end
    end
    res_q.push_back(r);
  endtask

  task automatic launch(input string name);
    int n;
    start_sig = 1'b0;
    repeat (4) @(negedge clk);
    start_sig = 1'b1;
    n = 0;
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!busy) fail_now({name, "_launch"});
    else begin
      check({name, "_done_cleared"}, (CH*DW)'(done_sig), '0);
      check({name, "_data_cleared"}, data, '0);
      check({name, "_err_cleared"}, (CH*DW)'(err), '0);
    end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done_sig && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!done_sig) fail_now({name, "_done_wait"});
    repeat (2) @(negedge clk);
    check({name, "_conv_count"}, (CH*DW)'(ch_q.size()), '0);
    check({name, "_results_left"}, (CH*DW)'(res_q.size()), '0);
  endtask

  task automatic wait_ch(input logic [CHW-1:0] c, input string name);
    int n;
    n = 0;
    while (ch_sel != c && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (ch_sel != c) fail_now(name);
  endtask

  initial begin
    int d0;
    rst = 1'b1;
    start_sig = 1'b1;
    adc_data = '0;
    adc_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ch_sel", (CH*DW)'(ch_sel), '0);
    check("rst_adc_start", (CH*DW)'(adc_start), '0);
    check("rst_busy", (CH*DW)'(busy), '0);
    check("rst_done", (CH*DW)'(done_sig), '0);
    check("rst_err", (CH*DW)'(err), '0);
    check("rst_data", data, '0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("no_run_without_toggle", (CH*DW)'(busy), '0);

    // Normal run.
    data_base = 16'h0100; silent_ch = -1;
    expect_run(16'h0100, -1);
    launch("normal");
    wait_done("normal");

    // Timeout on channel 7, relaunched from DONE.
    silent_ch = 7;
    expect_run(16'h0100, 7);
    launch("timeout");
    wait_done("timeout");
    check("timeout_err_vec", (CH*DW)'(err), (CH*DW)'(20'h00080));

    // Second start edge mid-run is ignored.
    silent_ch = -1; data_base = 16'h0200;
    expect_run(16'h0200, -1);
    d0 = done_cnt;
    launch("relaunch");
    wait_ch(5'd5, "reach_ch5");
    start_sig = 1'b0;
    repeat (4) @(negedge clk);
    start_sig = 1'b1;
    wait_done("ignore_edge");
    repeat (20) @(negedge clk);
    check("done_once", (CH*DW)'(done_cnt - d0), (CH*DW)'(1));

    // Reset during channel 10 SETTLE.
    data_base = 16'h0300;
    expect_run(16'h0300, -1);
    launch("pre_abort");
    wait_ch(5'd10, "reach_ch10");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ch_sel", (CH*DW)'(ch_sel), '0);
    check("abort_busy", (CH*DW)'(busy), '0);
    check("abort_data", data, '0);
    check("abort_err", (CH*DW)'(err), '0);
    ch_q.delete();
    res_q.delete();
    d0 = done_cnt;
    repeat (60) @(negedge clk);
    check("abort_no_done", (CH*DW)'(done_cnt - d0), '0);
    check("abort_idle", (CH*DW)'(busy), '0);

    // Fresh full run after the abort.
    data_base = 16'h0400;
    expect_run(16'h0400, -1);
    launch("after_abort");
    wait_done("after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
